// File: rtl/vga_pkg.sv
// Shared timing-mode type, default 640x480 mode and the mode range-check helpers
// for the raster timing generator.
package vga_pkg;

  localparam int MODE_W = 16;
  localparam logic [MODE_W+1:0] TOT_ONE = {{(MODE_W+1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [MODE_W-1:0] h_active;
    logic [MODE_W-1:0] h_fp;
    logic [MODE_W-1:0] h_sync;
    logic [MODE_W-1:0] h_bp;
    logic [MODE_W-1:0] v_active;
    logic [MODE_W-1:0] v_fp;
    logic [MODE_W-1:0] v_sync;
    logic [MODE_W-1:0] v_bp;
    logic              h_pol;
    logic              v_pol;
  } vga_mode_t;

  localparam vga_mode_t VGA_MODE_640X480 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
    h_pol: 1'b0, v_pol: 1'b0
  };

  function automatic logic [MODE_W+1:0] h_total(input vga_mode_t m);
    return {2'b00, m.h_active} + {2'b00, m.h_fp} + {2'b00, m.h_sync} + {2'b00, m.h_bp};
  endfunction

  function automatic logic [MODE_W+1:0] v_total(input vga_mode_t m);
    return {2'b00, m.v_active} + {2'b00, m.v_fp} + {2'b00, m.v_sync} + {2'b00, m.v_bp};
  endfunction

  // A mode needs non-empty active and sync regions and totals that fit the counters.
  function automatic logic mode_valid(input vga_mode_t m, input int unsigned h_w,
                                      input int unsigned v_w);
    logic [MODE_W+1:0] h_lim;
    logic [MODE_W+1:0] v_lim;
    h_lim = TOT_ONE << h_w;
    v_lim = TOT_ONE << v_w;
    return (m.h_active != 16'd0) && (m.v_active != 16'd0) &&
           (m.h_sync != 16'd0) && (m.v_sync != 16'd0) &&
           (h_total(m) <= h_lim) && (v_total(m) <= v_lim);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap/load, plus active and sync region
// decode of the post-update count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              load,
  input  logic [W-1:0]      last,
  input  logic [MODE_W-1:0] act_len,
  input  logic [MODE_W-1:0] fp_len,
  input  logic [MODE_W-1:0] sync_len,
  output logic [W-1:0]      count,
  output logic [W-1:0]      count_nxt,
  output logic              wrap,
  output logic              active,
  output logic              sync_region
);

  logic [W-1:0]      count_r;
  logic [MODE_W+1:0] cnt_ext_s;
  logic [MODE_W+1:0] sync_start_s;
  logic [MODE_W+1:0] sync_end_s;

  assign wrap  = advance & (count_r == last);
  assign count = count_r;

  // Next position and region decode; the decode bounds come from the mode in force after this edge.
  always_comb begin
    if (load | wrap) begin
      count_nxt = {W{1'b0}};
    end else if (advance) begin
      count_nxt = count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_nxt = count_r;
    end
    cnt_ext_s    = (MODE_W+2)'(count_nxt);
    sync_start_s = {2'b00, act_len} + {2'b00, fp_len};
    sync_end_s   = sync_start_s + {2'b00, sync_len};
    active       = cnt_ext_s < {2'b00, act_len};
    sync_region  = (cnt_ext_s >= sync_start_s) & (cnt_ext_s < sync_end_s);
  end

  // Position register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else begin
      count_r <= count_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-reprogrammable raster timing generator: a shadowed mode is accepted over a
// valid/ready port and swapped in only at the last pixel of a frame.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_W      = 11,
  parameter int V_W      = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_ce,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [H_W-1:0] cfg_h_active,
  input  logic [H_W-1:0] cfg_h_fp,
  input  logic [H_W-1:0] cfg_h_sync,
  input  logic [H_W-1:0] cfg_h_bp,
  input  logic [V_W-1:0] cfg_v_active,
  input  logic [V_W-1:0] cfg_v_fp,
  input  logic [V_W-1:0] cfg_v_sync,
  input  logic [V_W-1:0] cfg_v_bp,
  input  logic           cfg_h_pol,
  input  logic           cfg_v_pol,
  output logic           cfg_err,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           n_blank,
  output logic           n_sync,
  output logic [H_W-1:0] col,
  output logic [V_W-1:0] row,
  output logic           sof,
  output logic           eol
);

  localparam vga_mode_t DEF_MODE = '{
    h_active: MODE_W'(H_ACTIVE), h_fp: MODE_W'(H_FP),
    h_sync:   MODE_W'(H_SYNC),   h_bp: MODE_W'(H_BP),
    v_active: MODE_W'(V_ACTIVE), v_fp: MODE_W'(V_FP),
    v_sync:   MODE_W'(V_SYNC),   v_bp: MODE_W'(V_BP),
    h_pol: H_POL, v_pol: V_POL
  };

  vga_mode_t live_r, shadow_r, live_nxt_s, cfg_mode_s;
  logic      pending_r, pending_nxt_s, cfg_ready_r, cfg_err_r;
  logic      xfer_s, cfg_ok_s, switch_s, eol_hit_s;
  logic [H_W-1:0] h_last_s, h_cnt_s, h_nxt_s, col_r;
  logic [V_W-1:0] v_last_s, v_cnt_s, v_nxt_s, row_r;
  logic      h_wrap_s, h_act_s, h_syn_s, v_wrap_s, v_act_s, v_syn_s;
  logic      hsync_r, vsync_r, de_r, n_sync_r, sof_r, eol_r;

  assign xfer_s   = cfg_valid & cfg_ready_r;
  assign cfg_ok_s = mode_valid(cfg_mode_s, H_W, V_W);
  assign switch_s = v_wrap_s & pending_r;
  assign h_last_s = H_W'(h_total(live_r) - TOT_ONE);
  assign v_last_s = V_W'(v_total(live_r) - TOT_ONE);
  assign eol_hit_s = ((MODE_W+2)'(h_nxt_s) + TOT_ONE) == {2'b00, live_nxt_s.h_active};

  // Offered mode widened to the common mode type, and the mode in force after this edge.
  always_comb begin
    cfg_mode_s = '{
      h_active: MODE_W'(cfg_h_active), h_fp: MODE_W'(cfg_h_fp),
      h_sync:   MODE_W'(cfg_h_sync),   h_bp: MODE_W'(cfg_h_bp),
      v_active: MODE_W'(cfg_v_active), v_fp: MODE_W'(cfg_v_fp),
      v_sync:   MODE_W'(cfg_v_sync),   v_bp: MODE_W'(cfg_v_bp),
      h_pol: cfg_h_pol, v_pol: cfg_v_pol
    };
    if (switch_s) begin
      live_nxt_s = shadow_r;
    end else begin
      live_nxt_s = live_r;
    end
  end

  // Pending flag: set by an accepted mode, cleared by the frame-boundary switch.
  always_comb begin
    pending_nxt_s = pending_r;
    if (switch_s) begin
      pending_nxt_s = 1'b0;
    end else if (xfer_s & cfg_ok_s) begin
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  vga_axis_counter #(.W(H_W)) u_h_axis (
    .clk(clk), .rst(rst), .advance(pix_ce), .load(switch_s), .last(h_last_s),
    .act_len(live_nxt_s.h_active), .fp_len(live_nxt_s.h_fp), .sync_len(live_nxt_s.h_sync),
    .count(h_cnt_s), .count_nxt(h_nxt_s), .wrap(h_wrap_s),
    .active(h_act_s), .sync_region(h_syn_s)
  );

  vga_axis_counter #(.W(V_W)) u_v_axis (
    .clk(clk), .rst(rst), .advance(h_wrap_s), .load(switch_s), .last(v_last_s),
    .act_len(live_nxt_s.v_active), .fp_len(live_nxt_s.v_fp), .sync_len(live_nxt_s.v_sync),
    .count(v_cnt_s), .count_nxt(v_nxt_s), .wrap(v_wrap_s),
    .active(v_act_s), .sync_region(v_syn_s)
  );

  // Mode registers and config handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      live_r      <= DEF_MODE;
      shadow_r    <= DEF_MODE;
      pending_r   <= 1'b0;
      cfg_ready_r <= 1'b1;
      cfg_err_r   <= 1'b0;
    end else begin
      live_r      <= live_nxt_s;
      shadow_r    <= (xfer_s & cfg_ok_s) ? cfg_mode_s : shadow_r;
      pending_r   <= pending_nxt_s;
      cfg_ready_r <= ~pending_nxt_s;
      cfg_err_r   <= xfer_s & ~cfg_ok_s;
    end
  end

  // Raster outputs follow the post-update position and hold while pix_ce is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_r  <= ~H_POL;
      vsync_r  <= ~V_POL;
      de_r     <= 1'b1;
      n_sync_r <= 1'b1;
      col_r    <= {H_W{1'b0}};
      row_r    <= {V_W{1'b0}};
      sof_r    <= 1'b0;
      eol_r    <= 1'b0;
    end else begin
      if (pix_ce) begin
        hsync_r  <= h_syn_s ? live_nxt_s.h_pol : ~live_nxt_s.h_pol;
        vsync_r  <= v_syn_s ? live_nxt_s.v_pol : ~live_nxt_s.v_pol;
        de_r     <= h_act_s & v_act_s;
        n_sync_r <= ~(h_syn_s | v_syn_s);
        col_r    <= h_act_s ? h_nxt_s : col_r;
        row_r    <= v_act_s ? v_nxt_s : row_r;
      end
      sof_r <= v_wrap_s;
      eol_r <= pix_ce & eol_hit_s;
    end
  end

  assign cfg_ready = cfg_ready_r;
  assign cfg_err   = cfg_err_r;
  assign hsync     = hsync_r;
  assign vsync     = vsync_r;
  assign de        = de_r;
  assign n_blank   = de_r;
  assign n_sync    = n_sync_r;
  assign col       = col_r;
  assign row       = row_r;
  assign sof       = sof_r;
  assign eol       = eol_r;

endmodule
